hub75_scan_engine: RTL and testbench

Parametrised HUB75 scan engine replacing the fixed 64x32, 6-bit scanner. It sequences column shifting, row latching and binary-coded-modulation (BCM) output-enable timing for any column count, scan-row count, bit depth and number of parallel RGB lanes. It requests per-pixel bitplane data from the framebuffer fetch side with a fixed one-cycle latency. An optional overlap mode shifts the next bitplane while the current one is displayed. It sits between the framebuffer fetch and the panel pin drivers, running on the matrix clock.

---
 rtl/hub75_pkg.sv | 19 +
 rtl/bcm_display_timer.sv | 33 +++
 rtl/hub75_scan_engine.sv | 162 ++++++++++++++++
 tb/tb_hub75_scan_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 scan engine.
package hub75_pkg;

    localparam int LANE_BITS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    // Counter/address width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// Bitplane on-time counter: loads BASE_TICKS<<plane and counts down to zero.
module bcm_display_timer
    import hub75_pkg::*;
#(
    parameter int BIT_DEPTH  = 6,
    parameter int BASE_TICKS = 4
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           load,
    input  logic [width_of(BIT_DEPTH)-1:0] plane,
    output logic                           last,
    output logic                           expired
);

    localparam int CNT_W = $clog2(BASE_TICKS << (BIT_DEPTH - 1)) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(BASE_TICKS) << plane;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last    = (cnt == CNT_W'(1));
    assign expired = (cnt == '0);

endmodule

// File: rtl/hub75_scan_engine.sv
// HUB75 scanner: column shift, row latch and BCM output-enable sequencing,
// with optional shifting of the next bitplane while the current one is lit.
module hub75_scan_engine
    import hub75_pkg::*;
#(
    parameter int COLUMNS      = 64,
    parameter int SCAN_ROWS    = 16,
    parameter int BIT_DEPTH    = 6,
    parameter int LANES        = 2,
    parameter int BASE_TICKS   = 4,
    parameter int LATCH_CYCLES = 1,
    parameter int OVERLAP      = 0
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [BIT_DEPTH-1:0]           brightness_enable,
    output logic                           pixel_request,
    output logic [width_of(COLUMNS)-1:0]   column_address,
    output logic [width_of(SCAN_ROWS)-1:0] row_address,
    output logic [width_of(BIT_DEPTH)-1:0] bitplane,
    input  logic [LANE_BITS*LANES-1:0]     pixel_data,
    output logic [LANE_BITS*LANES-1:0]     rgb_out,
    output logic                           clk_pixel,
    output logic                           row_latch,
    output logic                           output_enable,
    output logic [width_of(SCAN_ROWS)-1:0] row_address_active,
    output logic                           frame_start
);

    localparam int COL_W  = width_of(COLUMNS);
    localparam int ROW_W  = width_of(SCAN_ROWS);
    localparam int PL_W   = width_of(BIT_DEPTH);
    localparam int K_LAST = 2 * COLUMNS + 1;
    localparam int K_W    = width_of(2 * COLUMNS + 2);
    localparam int LC_W   = width_of(LATCH_CYCLES);
    localparam int RGB_W  = LANE_BITS * LANES;

    scan_state_t      state, state_nxt;
    logic [K_W-1:0]   shift_k;
    logic             shift_done;
    logic [ROW_W-1:0] row_q, act_row_q;
    logic [PL_W-1:0]  plane_q, disp_plane_q;
    logic [LC_W-1:0]  latch_cnt;
    logic [RGB_W-1:0] rgb_q;
    logic             clk_pix_q;

    logic shifting, k_last, shift_fin, disp_last, disp_expired, disp_fin;
    logic latch_last, latch_end;

    bcm_display_timer #(
        .BIT_DEPTH (BIT_DEPTH),
        .BASE_TICKS(BASE_TICKS)
    ) u_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (latch_end),
        .plane  (plane_q),
        .last   (disp_last),
        .expired(disp_expired)
    );

    always_comb begin
        // In overlap mode the shift side runs behind the lit plane until it completes.
        shifting   = (state == ST_SHIFT) ||
                     ((OVERLAP != 0) && (state == ST_DISPLAY) && !shift_done);
        k_last     = (shift_k == K_W'(K_LAST));
        shift_fin  = shift_done || (shifting && k_last);
        disp_fin   = disp_last || disp_expired;
        latch_last = (latch_cnt == LC_W'(LATCH_CYCLES - 1));
        latch_end  = (state == ST_LATCH) && latch_last;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (enable) state_nxt = ST_SHIFT;
            ST_SHIFT:   if (k_last) state_nxt = ST_BLANK;
            ST_BLANK:   state_nxt = ST_LATCH;
            ST_LATCH:   if (latch_last) state_nxt = ST_DISPLAY;
            ST_DISPLAY: begin
                if (disp_fin) begin
                    if (!enable)           state_nxt = ST_IDLE;
                    else if (OVERLAP == 0) state_nxt = ST_SHIFT;
                    else if (shift_fin)    state_nxt = ST_BLANK;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            shift_k      <= '0;
            shift_done   <= 1'b0;
            row_q        <= '0;
            plane_q      <= '0;
            disp_plane_q <= '0;
            act_row_q    <= '0;
            latch_cnt    <= '0;
            rgb_q        <= '0;
            clk_pix_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Even k>=2 means data went out last cycle; raise the panel clock now.
            clk_pix_q <= shifting && !shift_k[0] && (shift_k != '0);

            if (state == ST_LATCH) latch_cnt <= latch_cnt + LC_W'(1);
            else                   latch_cnt <= '0;

            if ((state == ST_LATCH) && (latch_cnt == '0)) act_row_q <= row_q;

            if (shifting && shift_k[0] && !k_last) rgb_q <= pixel_data;

            if (shifting) begin
                if (k_last) begin
                    shift_k    <= '0;
                    shift_done <= (state == ST_DISPLAY);
                end else begin
                    shift_k <= shift_k + K_W'(1);
                end
            end

            // Hand the shifted plane to the display side and step to the next one.
            if (latch_end) begin
                shift_k      <= '0;
                shift_done   <= 1'b0;
                disp_plane_q <= plane_q;
                if (plane_q == PL_W'(BIT_DEPTH - 1)) begin
                    plane_q <= '0;
                    row_q   <= (row_q == ROW_W'(SCAN_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                end else begin
                    plane_q <= plane_q + PL_W'(1);
                end
            end

            if (state_nxt == ST_IDLE) begin
                shift_k    <= '0;
                shift_done <= 1'b0;
                row_q      <= '0;
                plane_q    <= '0;
                act_row_q  <= '0;
                rgb_q      <= '0;
                clk_pix_q  <= 1'b0;
            end
        end
    end

    assign pixel_request      = shifting && !shift_k[0] && (shift_k != K_W'(2 * COLUMNS));
    assign column_address     = COL_W'(shift_k >> 1);
    assign row_address        = row_q;
    assign bitplane           = plane_q;
    assign frame_start        = pixel_request && (shift_k == '0) && (row_q == '0) && (plane_q == '0);
    assign rgb_out            = rgb_q;
    assign clk_pixel          = clk_pix_q;
    assign row_latch          = (state == ST_LATCH);
    assign output_enable      = (state == ST_DISPLAY) && !disp_expired &&
                                brightness_enable[disp_plane_q];
    assign row_address_active = act_row_q;

endmodule

// File: tb/tb_hub75_scan_engine.sv
// Directed bench: a plain scanner (BASE_TICKS=3) and an overlapped one (BASE_TICKS=8).
module tb_hub75_scan_engine;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] brightness_enable = 2'b11;

    always #5 clk_in = ~clk_in;

    logic       req0, clkp0, latch0, oe0, fs0, row0, bp0, act0;
    logic [1:0] col0;
    logic [5:0] pd0 = '0, rgb0;
    logic       req1, clkp1, latch1, oe1, fs1, row1, bp1, act1;
    logic [1:0] col1;
    logic [5:0] pd1 = '0, rgb1;

    hub75_scan_engine #(
        .COLUMNS(4), .SCAN_ROWS(2), .BIT_DEPTH(2), .LANES(2),
        .BASE_TICKS(3), .LATCH_CYCLES(1), .OVERLAP(0)
    ) u_dut0 (
        .clk_in(clk_in), .reset(reset), .enable(enable),
        .brightness_enable(brightness_enable),
        .pixel_request(req0), .column_address(col0), .row_address(row0),
        .bitplane(bp0), .pixel_data(pd0), .rgb_out(rgb0), .clk_pixel(clkp0),
        .row_latch(latch0), .output_enable(oe0), .row_address_active(act0),
        .frame_start(fs0)
    );

    hub75_scan_engine #(
        .COLUMNS(4), .SCAN_ROWS(2), .BIT_DEPTH(2), .LANES(2),
        .BASE_TICKS(8), .LATCH_CYCLES(1), .OVERLAP(1)
    ) u_dut1 (
        .clk_in(clk_in), .reset(reset), .enable(enable),
        .brightness_enable(brightness_enable),
        .pixel_request(req1), .column_address(col1), .row_address(row1),
        .bitplane(bp1), .pixel_data(pd1), .rgb_out(rgb1), .clk_pixel(clkp1),
        .row_latch(latch1), .output_enable(oe1), .row_address_active(act1),
        .frame_start(fs1)
    );

    // Framebuffer model: one-cycle latency, pixel word encodes {row, plane, column}.
    always @(posedge clk_in) begin
        pd0 <= req0 ? {2'b10, row0, bp0, col0} : 6'd0;
        pd1 <= req1 ? {2'b10, row1, bp1, col1} : 6'd0;
    end

    int   cyc = 0;
    logic p_latch0 = 1'b0, p_latch1 = 1'b0, p_clkp0 = 1'b0;
    logic [5:0] p_rgb0 = '0;
    always @(posedge clk_in) begin
        cyc      <= cyc + 1;
        p_latch0 <= latch0;
        p_latch1 <= latch1;
        p_clkp0  <= clkp0;
        p_rgb0   <= rgb0;
    end

    int both_hi = 0;
    always @(negedge clk_in)
        if ((latch0 && oe0) || (latch1 && oe1)) both_hi++;

    int errors = 0;
    int checks = 0;

    function automatic logic sel(input int which);
        case (which)
            0:       return fs0;
            1:       return fs1;
            2:       return latch0 && !p_latch0;
            3:       return latch1 && !p_latch1;
            default: return clkp0 && !p_clkp0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!sel(which) && n < 300);
        if (!sel(which)) begin
            checks++; errors++;
            $display("FAIL %s timeout after %0d cycles", tag, n);
        end
    endtask

    task automatic oe_window(input int dut, input string tag, output int cnt);
        int n = 0;
        cnt = 0;
        do begin
            @(negedge clk_in);
            n++;
            if ((dut == 0) ? oe0 : oe1) cnt++;
        end while (!sel((dut == 0) ? 2 : 3) && n < 300);
        if (!sel((dut == 0) ? 2 : 3)) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting row_latch", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({req0, clkp0, latch0, oe0, fs0, col0, row0, bp0, act0, rgb0} !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut0 got %h expected 0000",
                     {req0, clkp0, latch0, oe0, fs0, col0, row0, bp0, act0, rgb0});
        end
        checks++;
        if ({req1, clkp1, latch1, oe1, fs1, col1, row1, bp1, act1, rgb1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut1 got %h expected 0000",
                     {req1, clkp1, latch1, oe1, fs1, col1, row1, bp1, act1, rgb1});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({req0, latch0, oe0, clkp0} !== 4'b0) begin
            errors++;
            $display("FAIL idle_disabled got %b expected 0000", {req0, latch0, oe0, clkp0});
        end
    endtask

    task automatic test_frame_period();
        int t0;
        enable = 1'b1;
        wait_for(0, "fs_first");
        t0 = cyc;
        checks++;
        if ({req0, row0, bp0, col0} !== 5'b10000) begin
            errors++;
            $display("FAIL fs_address got %b expected 10000", {req0, row0, bp0, col0});
        end
        wait_for(0, "fs_second");
        checks++;
        if (cyc - t0 !== 66) begin
            errors++;
            $display("FAIL frame_period got %0d expected 66", cyc - t0);
        end
    endtask

    task automatic test_plane_period();
        int ta, tb;
        wait_for(0, "pp_fs");
        wait_for(2, "pp_latch_a");
        ta = cyc;
        wait_for(2, "pp_latch_b");
        tb = cyc;
        checks++;
        if (tb - ta !== 15) begin
            errors++;
            $display("FAIL plane0_period got %0d expected 15", tb - ta);
        end
        wait_for(2, "pp_latch_c");
        checks++;
        if (cyc - tb !== 18) begin
            errors++;
            $display("FAIL plane1_period got %0d expected 18", cyc - tb);
        end
        checks++;
        if (act0 !== 1'b0) begin
            errors++;
            $display("FAIL active_row_before got %b expected 0", act0);
        end
        @(negedge clk_in);
        checks++;
        if (act0 !== 1'b1) begin
            errors++;
            $display("FAIL active_row_after got %b expected 1", act0);
        end
    endtask

    task automatic test_shift_data();
        int edges = 0;
        int n = 0;
        logic [5:0] exp;
        logic [3:0] nn;
        wait_for(0, "sd_fs");
        do begin
            @(negedge clk_in);
            n++;
            if (clkp0 && !p_clkp0) edges++;
        end while (!(latch0 && !p_latch0) && n < 300);
        checks++;
        if (edges !== 4) begin
            errors++;
            $display("FAIL clk_pixel_edges got %0d expected 4", edges);
        end
        wait_for(0, "sd_fs2");
        for (int e = 0; e < 16; e++) begin
            wait_for(4, "sd_edge");
            nn  = 4'(e);
            exp = {2'b10, nn};
            checks++;
            if (rgb0 !== exp) begin
                errors++;
                $display("FAIL rgb_value edge %0d got %h expected %h", e, rgb0, exp);
            end
            checks++;
            if (rgb0 !== p_rgb0) begin
                errors++;
                $display("FAIL rgb_stable edge %0d got %h expected %h", e, p_rgb0, rgb0);
            end
        end
    endtask

    task automatic test_brightness();
        int c;
        brightness_enable = 2'b10;
        wait_for(0, "br_fs");
        oe_window(0, "br_pre", c);
        oe_window(0, "br_p0", c);
        checks++;
        if (c !== 0) begin errors++; $display("FAIL oe_mask10_p0 got %0d expected 0", c); end
        oe_window(0, "br_p1", c);
        checks++;
        if (c !== 6) begin errors++; $display("FAIL oe_mask10_p1 got %0d expected 6", c); end
        brightness_enable = 2'b01;
        wait_for(0, "br_fs2");
        oe_window(0, "br_pre2", c);
        oe_window(0, "br_p0b", c);
        checks++;
        if (c !== 3) begin errors++; $display("FAIL oe_mask01_p0 got %0d expected 3", c); end
        oe_window(0, "br_p1b", c);
        checks++;
        if (c !== 0) begin errors++; $display("FAIL oe_mask01_p1 got %0d expected 0", c); end
        brightness_enable = 2'b11;
    endtask

    task automatic test_overlap();
        int t0, ta, c;
        wait_for(1, "ov_fs1");
        t0 = cyc;
        wait_for(1, "ov_fs2");
        checks++;
        if (cyc - t0 !== 60) begin
            errors++;
            $display("FAIL overlap_frame_period got %0d expected 60", cyc - t0);
        end
        oe_window(1, "ov_pre", c);
        ta = cyc;
        oe_window(1, "ov_p0", c);
        checks++;
        if (c !== 8) begin errors++; $display("FAIL overlap_p0_oe got %0d expected 8", c); end
        checks++;
        if (cyc - ta !== 12) begin
            errors++;
            $display("FAIL overlap_p0_period got %0d expected 12", cyc - ta);
        end
        ta = cyc;
        oe_window(1, "ov_p1", c);
        checks++;
        if (c !== 16) begin errors++; $display("FAIL overlap_p1_oe got %0d expected 16", c); end
        checks++;
        if (cyc - ta !== 18) begin
            errors++;
            $display("FAIL overlap_p1_period got %0d expected 18", cyc - ta);
        end
    endtask

    task automatic test_enable();
        int n = 0;
        int lat = 0;
        int oes = 0;
        while (!(req0 && row0 === 1'b1 && bp0 === 1'b0 && col0 === 2'd1) && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL en_wait timeout finding row1 plane0 shift");
        end
        enable = 1'b0;
        repeat (40) begin
            @(negedge clk_in);
            if (latch0 && !p_latch0) lat++;
            if (oe0) oes++;
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL en_drop_latches got %0d expected 1", lat); end
        checks++;
        if (oes !== 3) begin errors++; $display("FAIL en_drop_oe got %0d expected 3", oes); end
        checks++;
        if ({req0, clkp0, latch0, oe0, fs0, col0, row0, bp0, act0, rgb0} !== 16'h0) begin
            errors++;
            $display("FAIL en_idle_outputs got %h expected 0000",
                     {req0, clkp0, latch0, oe0, fs0, col0, row0, bp0, act0, rgb0});
        end
        enable = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({fs0, req0, row0, bp0, col0} !== 6'b110000) begin
            errors++;
            $display("FAIL en_restart got %b expected 110000", {fs0, req0, row0, bp0, col0});
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int lat = 0;
        while (oe0 !== 1'b1 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (oe0 !== 1'b1) begin errors++; $display("FAIL rm_wait got oe %b expected 1", oe0); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({oe0, latch0, clkp0, req0, act0, rgb0} !== 11'h0) begin
            errors++;
            $display("FAIL rm_async_clear got %h expected 000",
                     {oe0, latch0, clkp0, req0, act0, rgb0});
        end
        @(negedge clk_in);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (latch0) lat++;
        end while (req0 !== 1'b1 && n < 50);
        checks++;
        if ({fs0, req0, row0, bp0, col0} !== 6'b110000) begin
            errors++;
            $display("FAIL rm_resume got %b expected 110000", {fs0, req0, row0, bp0, col0});
        end
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL rm_latch_glitch got %0d expected 0", lat); end
    endtask

    initial begin
        test_reset();
        test_frame_period();
        test_plane_period();
        test_shift_data();
        test_brightness();
        test_overlap();
        test_enable();
        test_reset_mid();
        checks++;
        if (both_hi !== 0) begin
            errors++;
            $display("FAIL latch_oe_exclusive got %0d expected 0", both_hi);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
